// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between requester A (fetch) and B (data/IO).
// One access is in flight at a time: IDLE -> ISSUE -> WAIT (RAM_LAT cycles) -> ISSUE | IDLE.
// Out-of-range addresses (any bit above RAM_AW set) never write the RAM and read back as 0.
// Build option: define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise A has fixed priority.
module ram_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RAM_AW  = 8,
  parameter int unsigned RAM_LAT = 1  // legal 1..3
) (
  input  logic              clk,
  input  logic              rst_n,
  // Port A
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  // Port B
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  // RAM side
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  // Value of the latency counter in the final WAIT cycle.
  localparam logic [1:0] LatLast = 2'(RAM_LAT - 1);

  state_e              state_q, state_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic                sel_b_q, sel_b_d;  // winner of the access in flight
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
`ifdef RAM_ARB_RR_EN
  logic                last_b_q, last_b_d;  // 1: B was granted most recently
`endif

  logic                arb_en;
  logic                pick_b;
  logic                in_range;
  logic                issue;
  logic                last_wait;
  logic [DATA_W-1:0]   rd_val;

  // Winner selection for the current arbitration edge.
  always_comb begin
`ifdef RAM_ARB_RR_EN
    pick_b = (a_req && b_req) ? ~last_b_q : b_req;
`else
    pick_b = b_req & ~a_req;
`endif
  end

  // Decode of the latched access and of the current FSM phase.
  always_comb begin
    in_range  = ~|addr_q[ADDR_W-1:RAM_AW];
    issue     = (state_q == StIssue);
    last_wait = (state_q == StWait) && (lat_cnt_q == LatLast);
    rd_val    = in_range ? ram_dout : '0;
  end

  // Next-state: FSM sequencing, arbitration and request latching.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    sel_b_d   = sel_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    arb_en    = 1'b0;
`ifdef RAM_ARB_RR_EN
    last_b_d  = last_b_q;
`endif
    unique case (state_q)
      StIdle:  arb_en = 1'b1;
      StIssue: begin
        state_d   = StWait;
        lat_cnt_d = 2'd0;
      end
      StWait: begin
        if (lat_cnt_q == LatLast) begin
          arb_en = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (arb_en) begin
      if (a_req || b_req) begin
        state_d  = StIssue;
        sel_b_d  = pick_b;
        we_d     = pick_b ? b_we : a_we;
        addr_d   = pick_b ? b_addr : a_addr;
        din_d    = pick_b ? b_din : a_din;
`ifdef RAM_ARB_RR_EN
        last_b_d = pick_b;
`endif
      end else begin
        state_d = StIdle;
      end
    end
  end

  // Per-port outputs; read data is visible in the done cycle and held afterwards.
  always_comb begin
    a_gnt     = issue & ~sel_b_q;
    b_gnt     = issue & sel_b_q;
    a_done    = last_wait & ~sel_b_q;
    b_done    = last_wait & sel_b_q;
    a_err     = a_done & ~in_range;
    b_err     = b_done & ~in_range;
    a_rdata_d = (a_done && !we_q) ? rd_val : a_rdata_q;
    b_rdata_d = (b_done && !we_q) ? rd_val : b_rdata_q;
    a_rdata   = a_rdata_d;
    b_rdata   = b_rdata_d;
    ram_we    = issue & we_q & in_range;
    ram_addr  = addr_q[RAM_AW-1:0];
    ram_din   = din_q;
    busy      = (state_q != StIdle);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lat_cnt_q <= 2'd0;
      sel_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef RAM_ARB_RR_EN
      last_b_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      sel_b_q   <= sel_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifdef RAM_ARB_RR_EN
      last_b_q  <= last_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with RAM_LAT=3: directed scenarios with literal expectations plus
// randomized two-port traffic, all checked every cycle against a transaction-timing model.
module tb_ram_arbiter;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = '0, a_din = '0, b_addr = '0, b_din = '0;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err, ram_we, busy;
  logic [15:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [7:0]  ram_addr;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .DATA_W (16),
    .ADDR_W (16),
    .RAM_AW (8),
    .RAM_LAT(LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_din   (a_din),
    .a_gnt   (a_gnt),
    .a_done  (a_done),
    .a_rdata (a_rdata),
    .a_err   (a_err),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_din   (b_din),
    .b_gnt   (b_gnt),
    .b_done  (b_done),
    .b_rdata (b_rdata),
    .b_err   (b_err),
    .ram_we  (ram_we),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_dout(ram_dout),
    .busy    (busy)
  );

  // Block RAM stand-in: 256 x 16, write on we, read data after LAT clocks.
  logic [15:0] mem [256] = '{default: 16'h0};
  logic [15:0] rd_pipe [LAT] = '{default: 16'h0};
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: an accepted access at edge g owns cycles g..g+LAT (gnt at offset 0,
  // done at offset LAT); the next arbitration edge is g+LAT+1.
  int unsigned e = 0;
  int unsigned m_g = 0;
  bit          m_act = 0, m_b = 0, m_we = 0, m_oor = 0, m_lastb = 1;
  logic [15:0] m_rv = '0, m_hold_a = '0, m_hold_b = '0, m_ram_din = '0;
  logic [7:0]  m_ram_addr = '0;
  logic [15:0] ref_mem [256] = '{default: 16'h0};

  initial begin : model
    bit free, pb, oor, w;
    logic [15:0] ad, dn;
    forever begin
      @(posedge clk);
      e++;
      if (!rst_n) begin
        m_act = 0; m_hold_a = '0; m_hold_b = '0; m_ram_addr = '0; m_ram_din = '0; m_lastb = 1;
      end else begin
        free = !m_act;
        if (m_act && (e - m_g) == LAT + 1) begin
          if (!m_we) begin
            if (m_b) m_hold_b = m_rv;
            else m_hold_a = m_rv;
          end
          m_act = 0;
          free  = 1;
        end
        if (free && (a_req || b_req)) begin
`ifdef RAM_ARB_RR_EN
          pb = (a_req && b_req) ? !m_lastb : b_req;
`else
          pb = b_req && !a_req;
`endif
          w   = pb ? b_we : a_we;
          ad  = pb ? b_addr : a_addr;
          dn  = pb ? b_din : a_din;
          oor = (ad[15:8] != 8'h00);
          if (w && !oor) ref_mem[ad[7:0]] = dn;
          m_rv = oor ? 16'h0 : ref_mem[ad[7:0]];
          m_act = 1; m_g = e; m_b = pb; m_we = w; m_oor = oor; m_lastb = pb;
          m_ram_addr = ad[7:0]; m_ram_din = dn;
        end
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial begin : compare
    int unsigned k;
    bit eg, ed;
    logic [15:0] ra, rb;
    logic [63:0] act, exp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        k  = e - m_g;
        eg = m_act && (k == 0);
        ed = m_act && (k == LAT);
        ra = (ed && !m_b && !m_we) ? m_rv : m_hold_a;
        rb = (ed && m_b && !m_we) ? m_rv : m_hold_b;
        exp = {eg && !m_b, ed && !m_b, ed && !m_b && m_oor, eg && m_b, ed && m_b, ed && m_b && m_oor,
               eg && m_we && !m_oor, m_act, m_ram_addr, m_ram_din, ra, rb};
        act = {a_gnt, a_done, a_err, b_gnt, b_done, b_err, ram_we, busy, ram_addr, ram_din,
               a_rdata, b_rdata};
        chk($sformatf("cycle%0d", e), act, exp);
      end
    end
  end

  // Single access on one port; returns edges-since-request of gnt and done plus observations.
  task automatic access(input bit pb, input bit we, input logic [15:0] addr, input logic [15:0] din,
                        output int g_at, output int d_at, output logic [15:0] rd, output bit er,
                        output int we_cnt, output bit other);
    int n = 0;
    g_at = -1; d_at = -1; rd = '0; er = 0; we_cnt = 0; other = 0;
    @(posedge clk); #1;
    if (pb) begin b_we = we; b_addr = addr; b_din = din; b_req = 1; end
    else    begin a_we = we; a_addr = addr; a_din = din; a_req = 1; end
    while (d_at < 0 && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (pb ? b_gnt : a_gnt) begin
        if (g_at < 0) g_at = n;
        a_req = 0; b_req = 0;
      end
      if (pb ? b_done : a_done) begin
        d_at = n;
        rd   = pb ? b_rdata : a_rdata;
        er   = pb ? b_err : a_err;
      end
      other |= pb ? (a_gnt | a_done | a_err) : (b_gnt | b_done | b_err);
    end
    a_req = 0; b_req = 0;
  endtask

  task automatic rand_fields(output logic we, output logic [15:0] addr, output logic [15:0] din);
    int unsigned r = $urandom_range(0, 9);
    we  = 1'($urandom_range(0, 1));
    din = 16'($urandom);
    if (r == 0)      addr = {8'($urandom_range(1, 255)), 8'($urandom)};
    else if (r == 1) addr = 16'h00FF;
    else             addr = 16'($urandom_range(0, 31));
  endtask

  initial begin : main
    int g, d, wc, n, ng, nd, d0, d1;
    logic [15:0] rd, r0, r1;
    bit er, oth, both, seen;
    logic [3:0] seq;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("reset_outputs", {a_gnt, a_done, a_err, b_gnt, b_done, b_err, ram_we, busy, ram_addr,
                          ram_din, a_rdata, b_rdata}, 64'h0);
    rst_n = 1;

    // 1: A write 0x0010 <= 0xBEEF
    access(0, 1, 16'h0010, 16'hBEEF, g, d, rd, er, wc, oth);
    chk("t1_gnt_lat", g, 1);
    chk("t1_done_lat", d, 4);
    chk("t1_ram_we_cnt", wc, 1);
    chk("t1_err", er, 0);
    chk("t1_mem", mem[8'h10], 16'hBEEF);

    // 2: A read 0x0010
    access(0, 0, 16'h0010, 16'h0, g, d, rd, er, wc, oth);
    chk("t2_rdata", rd, 16'hBEEF);
    chk("t2_err", er, 0);
    chk("t2_b_quiet", oth, 0);
    chk("t2_b_rdata", b_rdata, 16'h0);
    @(negedge clk);
    chk("t2_rdata_held", a_rdata, 16'hBEEF);

    // 3: B write out of range
    access(1, 1, 16'h0100, 16'h1234, g, d, rd, er, wc, oth);
    chk("t3_gnt_lat", g, 1);
    chk("t3_done_lat", d, 4);
    chk("t3_err", er, 1);
    chk("t3_ram_we_cnt", wc, 0);
    chk("t3_mem0", mem[0], 16'h0);

    // 4: simultaneous held reads, grant order over four accesses
    @(posedge clk); #1;
    a_we = 0; a_addr = 16'h0010; a_req = 1;
    b_we = 0; b_addr = 16'h0020; b_req = 1;
    seq = '0; ng = 0; n = 0; both = 0;
    while (ng < 4 && n < 60) begin
      @(negedge clk); n++;
      if (a_gnt && b_gnt) both = 1;
      if (a_gnt || b_gnt) begin
        seq[ng] = b_gnt;
        ng++;
      end
    end
    a_req = 0; b_req = 0;
    repeat (LAT + 2) @(negedge clk);
    chk("t4_count", ng, 4);
    chk("t4_both_gnt", both, 0);
`ifdef RAM_ARB_RR_EN
    chk("t4_order", seq, 4'b1010);
`else
    chk("t4_order", seq, 4'b0000);
`endif

    // 5: reset during WAIT of an A read
    @(posedge clk); #1;
    a_we = 0; a_addr = 16'h0010; a_req = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_gnt", a_gnt, 1);
    a_req = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("t5_reset_outputs", {a_gnt, a_done, a_err, b_gnt, b_done, b_err, ram_we, busy, ram_addr,
                             ram_din, a_rdata, b_rdata}, 64'h0);
    chk("t5_busy", busy, 0);
    rst_n = 1;
    seen = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      seen |= a_done;
    end
    chk("t5_no_done", seen, 0);
    access(0, 0, 16'h0010, 16'h0, g, d, rd, er, wc, oth);
    chk("t5_next_rdata", rd, 16'hBEEF);
    chk("t5_next_done_lat", d, 4);

    // 6: back-to-back B reads of 0x05 and 0x06
    access(1, 1, 16'h0005, 16'h5A05, g, d, rd, er, wc, oth);
    access(1, 1, 16'h0006, 16'h5A06, g, d, rd, er, wc, oth);
    @(posedge clk); #1;
    b_we = 0; b_addr = 16'h0005; b_req = 1;
    ng = 0; nd = 0; n = 0; d0 = 0; d1 = 0; r0 = '0; r1 = '0;
    while (nd < 2 && n < 60) begin
      @(negedge clk); n++;
      if (b_gnt) begin
        ng++;
        if (ng == 1) b_addr = 16'h0006;
        else b_req = 0;
      end
      if (b_done) begin
        if (nd == 0) begin d0 = n; r0 = b_rdata; end
        else begin d1 = n; r1 = b_rdata; end
        nd++;
      end
    end
    b_req = 0;
    chk("t6_done_count", nd, 2);
    chk("t6_spacing", d1 - d0, 4);
    chk("t6_rdata0", r0, 16'h5A05);
    chk("t6_rdata1", r1, 16'h5A06);

    // Randomized traffic on both ports
    fork
      begin : drv_a
        logic w; logic [15:0] ad, dn;
        repeat (3000) begin
          @(posedge clk); #1;
          if (a_req && a_gnt) begin
            if ($urandom_range(0, 1) == 1) begin
              rand_fields(w, ad, dn);
              a_we = w; a_addr = ad; a_din = dn;
            end else a_req = 0;
          end else if (a_req) begin
            if ($urandom_range(0, 15) == 0) a_req = 0;
          end else if ($urandom_range(0, 2) == 0) begin
            rand_fields(w, ad, dn);
            a_we = w; a_addr = ad; a_din = dn; a_req = 1;
          end
        end
        a_req = 0;
      end
      begin : drv_b
        logic w; logic [15:0] ad, dn;
        repeat (3000) begin
          @(posedge clk); #1;
          if (b_req && b_gnt) begin
            if ($urandom_range(0, 1) == 1) begin
              rand_fields(w, ad, dn);
              b_we = w; b_addr = ad; b_din = dn;
            end else b_req = 0;
          end else if (b_req) begin
            if ($urandom_range(0, 15) == 0) b_req = 0;
          end else if ($urandom_range(0, 2) == 0) begin
            rand_fields(w, ad, dn);
            b_we = w; b_addr = ad; b_din = dn; b_req = 1;
          end
        end
        b_req = 0;
      end
    join
    repeat (LAT + 4) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
